// File: rtl/car_park_occupancy.sv
// car_park_occupancy: decodes a/b beam sequences into inc/dec pulses
// and a saturating count. Define CARPARK_SYNC_EN for 2-flop input sync.
module car_park_occupancy #(
  parameter int CNT_W   = 4,
  parameter int MAX_OCC = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  output logic             inc_pulse,
  output logic             dec_pulse,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic [2:0]       debug_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EN1   = 3'd1,
    EN2   = 3'd2,
    EN3   = 3'd3,
    EX1   = 3'd4,
    EX2   = 3'd5,
    EX3   = 3'd6,
    FAULT = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OCC);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic             a_s;
  logic             b_s;
  logic [1:0]       ab;
  logic             entry_done;
  logic             exit_done;
  logic [CNT_W-1:0] cnt_nxt;

`ifdef CARPARK_SYNC_EN
  logic [1:0] a_sync;
  logic [1:0] b_sync;

  // two-flop synchronizers, cleared on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sync <= 2'b00;
      b_sync <= 2'b00;
    end else begin
      a_sync <= {a_sync[0], a};
      b_sync <= {b_sync[0], b};
    end
  end

  assign a_s = a_sync[1];
  assign b_s = b_sync[1];
`else
  assign a_s = a;
  assign b_s = b;
`endif

  assign ab = {a_s, b_s};

  // next-state decode; completion flags fire on the final 00
  always_comb begin
    state_nxt  = state;
    entry_done = 1'b0;
    exit_done  = 1'b0;
    unique case (state)
      IDLE: begin
        case (ab)
          2'b10:   state_nxt = EN1;
          2'b01:   state_nxt = EX1;
          2'b11:   state_nxt = FAULT;
          default: state_nxt = IDLE;
        endcase
      end
      EN1: begin
        case (ab)
          2'b10:   state_nxt = EN1;
          2'b11:   state_nxt = EN2;
          2'b01:   state_nxt = FAULT;
          default: state_nxt = IDLE;
        endcase
      end
      EN2: begin
        case (ab)
          2'b11:   state_nxt = EN2;
          2'b01:   state_nxt = EN3;
          2'b10:   state_nxt = FAULT;
          default: state_nxt = IDLE;
        endcase
      end
      EN3: begin
        case (ab)
          2'b01:   state_nxt = EN3;
          2'b00: begin
            state_nxt  = IDLE;
            entry_done = 1'b1;
          end
          default: state_nxt = FAULT;
        endcase
      end
      EX1: begin
        case (ab)
          2'b01:   state_nxt = EX1;
          2'b11:   state_nxt = EX2;
          2'b10:   state_nxt = FAULT;
          default: state_nxt = IDLE;
        endcase
      end
      EX2: begin
        case (ab)
          2'b11:   state_nxt = EX2;
          2'b10:   state_nxt = EX3;
          2'b01:   state_nxt = FAULT;
          default: state_nxt = IDLE;
        endcase
      end
      EX3: begin
        case (ab)
          2'b10:   state_nxt = EX3;
          2'b00: begin
            state_nxt = IDLE;
            exit_done = 1'b1;
          end
          default: state_nxt = FAULT;
        endcase
      end
      FAULT: begin
        if (ab == 2'b00) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // saturating occupancy update
  always_comb begin
    cnt_nxt = count;
    unique case (1'b1)
      entry_done && (count < MAX_C):
        cnt_nxt = count + ONE_C;
      exit_done && (count != '0):
        cnt_nxt = count - ONE_C;
      default: cnt_nxt = count;
    endcase
  end

  // state, count, pulses and flags all registered together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      state     <= state_nxt;
      count     <= cnt_nxt;
      inc_pulse <= entry_done;
      dec_pulse <= exit_done;
      full      <= (cnt_nxt == MAX_C);
      empty     <= (cnt_nxt == '0);
    end
  end

  assign debug_state = state;

endmodule
